fetch_align_unit: RTL and testbench

- Instruction fetch front-end feeding the IF/ID pipeline register of the RV32IC core.
- Issues word-aligned reads to instruction memory and buffers the returned halfwords in a small queue.
- Delivers one aligned instruction per cycle with its PC: a 16-bit compressed instruction (zero-extended) or a 32-bit instruction, including 32-bit instructions that straddle a word boundary.
- Handles PC redirects from branch/jump resolution by flushing the queue and discarding in-flight data.

---
 rtl/fetch_align_unit_if.sv | 53 +++++
 rtl/fetch_align_unit.sv | 216 +++++++++++++++++++++
 tb/tb_fetch_align_unit.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_align_unit_if.sv
// Bus bundle for the fetch/align front-end: redirect input, instruction
// memory request/response channel and the aligned-instruction output.
// The master modport is the fetch unit; the slave modport is its environment
// (memory, branch resolution and the IF/ID register).
interface fetch_align_unit_if;
    // Redirect from branch/jump resolution
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    // Instruction memory channel
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    // Aligned instruction towards IF/ID
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_is_c_o;
    logic        inst_ready_i;

    modport master (
        input  redirect_i,
        input  redirect_pc_i,
        output mem_req_o,
        output mem_addr_o,
        input  mem_gnt_i,
        input  mem_rvalid_i,
        input  mem_rdata_i,
        output inst_valid_o,
        output inst_o,
        output inst_pc_o,
        output inst_is_c_o,
        input  inst_ready_i
    );

    modport slave (
        output redirect_i,
        output redirect_pc_i,
        input  mem_req_o,
        input  mem_addr_o,
        output mem_gnt_i,
        output mem_rvalid_i,
        output mem_rdata_i,
        input  inst_valid_o,
        input  inst_o,
        input  inst_pc_o,
        input  inst_is_c_o,
        output inst_ready_i
    );
endinterface

// File: rtl/fetch_align_unit.sv
// RV32IC fetch/align front-end. Fetches word-aligned instruction words,
// buffers them as halfwords in a small shift queue and presents one aligned
// instruction (16-bit compressed or 32-bit, possibly straddling a word
// boundary) per cycle together with its PC. Redirects flush the queue and
// discard any response still in flight.
// DEPTH is the queue capacity in halfwords; it must be even and >= 4.
module fetch_align_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst,    // asynchronous, active-low
    fetch_align_unit_if.master  bus
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    // Registered state
    state_t          r_state;
    logic [31:0]     r_fetch_addr;
    logic [31:0]     r_head_pc;
    logic            r_drop_low;
    logic [CW-1:0]   r_count;
    logic [15:0]     r_q [DEPTH];

    // Next-state and combinational signals
    state_t          w_state_next;
    logic [31:0]     w_fetch_addr_next;
    logic [31:0]     w_head_pc_next;
    logic            w_drop_low_next;
    logic [CW-1:0]   w_count_next;
    logic [15:0]     w_q_next [DEPTH];

    logic            w_redirect;
    logic            w_mem_req;
    logic            w_space;
    logic            w_grant;
    logic            w_fill;
    logic            w_pop;
    logic [1:0]      w_pop_n;
    logic [1:0]      w_fill_n;
    logic [15:0]     w_fill_h0;
    logic [15:0]     w_fill_h1;
    logic [CW-1:0]   w_keep;
    logic [15:0]     w_h0;
    logic [15:0]     w_h1;
    logic            w_is32;
    logic            w_inst_valid;
    logic            w_inst_is_c;
    logic [31:0]     w_inst;

    assign w_redirect = bus.redirect_i;
    assign w_h0       = r_q[0];
    assign w_h1       = r_q[1];
    assign w_is32     = (w_h0[1:0] == 2'b11);

    // A request reserves room for a full word even when only its upper
    // halfword will be kept; no fill can occur while in REQ, so count is exact.
    assign w_space = ((32'(r_count) + 32'd2) <= 32'(DEPTH));

    // Redirect wins over grant, fill and pop in the same cycle.
    assign w_grant = w_mem_req & bus.mem_gnt_i;
    assign w_fill  = (r_state == S_WAIT) & bus.mem_rvalid_i & ~w_redirect;
    assign w_pop   = w_inst_valid & bus.inst_ready_i & ~w_redirect;

    assign w_pop_n   = w_pop ? (w_is32 ? 2'd2 : 2'd1) : 2'd0;
    assign w_fill_n  = w_fill ? (r_drop_low ? 2'd1 : 2'd2) : 2'd0;
    assign w_fill_h0 = r_drop_low ? bus.mem_rdata_i[31:16] : bus.mem_rdata_i[15:0];
    assign w_fill_h1 = bus.mem_rdata_i[31:16];
    assign w_keep    = r_count - CW'(w_pop_n);

    // Per-entry queue update: surviving entries shift towards the head by the
    // pop amount, and fresh halfwords land directly behind the survivors.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [15:0] w_sh1;
        logic [15:0] w_sh2;
        logic [15:0] w_kept;

        if (gi + 2 < DEPTH) begin : g_mid
            assign w_sh1 = r_q[gi + 1];
            assign w_sh2 = r_q[gi + 2];
        end else if (gi + 1 < DEPTH) begin : g_penult
            assign w_sh1 = r_q[gi + 1];
            assign w_sh2 = 16'h0000;
        end else begin : g_tail
            assign w_sh1 = 16'h0000;
            assign w_sh2 = 16'h0000;
        end

        assign w_kept = (w_pop_n == 2'd2) ? w_sh2 :
                        (w_pop_n == 2'd1) ? w_sh1 : r_q[gi];

        assign w_q_next[gi] =
            (CW'(gi) < w_keep)                                   ? w_kept    :
            ((CW'(gi) == w_keep) && (w_fill_n != 2'd0))          ? w_fill_h0 :
            ((CW'(gi) == (w_keep + CW'(1))) && (w_fill_n == 2'd2)) ? w_fill_h1 :
                                                                   r_q[gi];
    end

    // Datapath next-state: count, head PC, fetch address and drop_low flag
    always_comb begin
        w_count_next      = w_keep + CW'(w_fill_n);
        w_head_pc_next    = r_head_pc;
        w_fetch_addr_next = r_fetch_addr;
        w_drop_low_next   = r_drop_low;
        if (w_pop) begin
            w_head_pc_next = r_head_pc + (w_is32 ? 32'd4 : 32'd2);
        end
        if (w_grant) begin
            w_fetch_addr_next = r_fetch_addr + 32'd4;
        end
        if (w_fill) begin
            w_drop_low_next = 1'b0;
        end
        if (w_redirect) begin
            w_count_next      = '0;
            w_head_pc_next    = bus.redirect_pc_i & ~32'd1;
            w_fetch_addr_next = bus.redirect_pc_i & ~32'd3;
            w_drop_low_next   = bus.redirect_pc_i[1];
        end
    end

    // Datapath registers, including the halfword queue
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count      <= '0;
            r_head_pc    <= RESET_PC & ~32'd1;
            r_fetch_addr <= RESET_PC & ~32'd3;
            r_drop_low   <= RESET_PC[1];
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= 16'h0000;
            end
        end else begin
            r_count      <= w_count_next;
            r_head_pc    <= w_head_pc_next;
            r_fetch_addr <= w_fetch_addr_next;
            r_drop_low   <= w_drop_low_next;
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= w_q_next[i];
            end
        end
    end

    // Fetch FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Fetch FSM next-state. A response that arrives in the same cycle as a
    // redirect is dropped, but it still retires the outstanding request, so
    // the FSM returns to REQ rather than waiting for a response that will
    // never come.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_REQ: begin
                if (w_grant) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.mem_rvalid_i) begin
                    w_state_next = S_REQ;
                end else if (w_redirect) begin
                    w_state_next = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (bus.mem_rvalid_i) begin
                    w_state_next = S_REQ;
                end
            end
            default: w_state_next = S_REQ;
        endcase
    end

    // Fetch FSM outputs; the request is forced low while reset is asserted
    always_comb begin
        w_mem_req = (r_state == S_REQ) && w_space && !w_redirect && rst;
    end

    // Instruction alignment from the head of the queue
    always_comb begin
        w_inst_valid = 1'b0;
        w_inst_is_c  = 1'b0;
        w_inst       = 32'h0000_0000;
        if (!w_is32) begin
            if (r_count >= CW'(1)) begin
                w_inst_valid = 1'b1;
                w_inst_is_c  = 1'b1;
                w_inst       = {16'h0000, w_h0};
            end
        end else if (r_count >= CW'(2)) begin
            w_inst_valid = 1'b1;
            w_inst       = {w_h1, w_h0};
        end
    end

    assign bus.mem_req_o    = w_mem_req;
    assign bus.mem_addr_o   = r_fetch_addr;
    assign bus.inst_valid_o = w_inst_valid;
    assign bus.inst_is_c_o  = w_inst_is_c;
    assign bus.inst_o       = w_inst;
    assign bus.inst_pc_o    = r_head_pc;

endmodule

// File: tb/tb_fetch_align_unit.sv
// Directed bench for fetch_align_unit: one instance with RESET_PC = 0 served
// by a small memory responder, one with RESET_PC = 0x80 driven by hand.
module tb_fetch_align_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0;
    logic rst1;

    fetch_align_unit_if if0 ();
    fetch_align_unit_if if1 ();

    fetch_align_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (if0.master)
    );

    fetch_align_unit #(.RESET_PC(32'h0000_0080), .DEPTH(4)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (if1.master)
    );

    // Memory model for dut0: always grants, answers after lat cycles
    logic [31:0] mem [0:255];
    int          lat;
    logic        pend;
    int          wcnt;
    logic [31:0] paddr;

    assign if0.mem_gnt_i = if0.mem_req_o;

    always @(posedge clk or negedge rst0) begin
        if (!rst0) begin
            pend             <= 1'b0;
            wcnt             <= 0;
            paddr            <= 32'h0;
            if0.mem_rvalid_i <= 1'b0;
            if0.mem_rdata_i  <= 32'h0;
        end else begin
            if0.mem_rvalid_i <= 1'b0;
            if (pend) begin
                if (wcnt == 0) begin
                    if0.mem_rvalid_i <= 1'b1;
                    if0.mem_rdata_i  <= mem[paddr[9:2]];
                    pend             <= 1'b0;
                end else begin
                    wcnt <= wcnt - 1;
                end
            end else if (if0.mem_req_o && if0.mem_gnt_i) begin
                if (lat <= 1) begin
                    if0.mem_rvalid_i <= 1'b1;
                    if0.mem_rdata_i  <= mem[if0.mem_addr_o[9:2]];
                end else begin
                    pend  <= 1'b1;
                    paddr <= if0.mem_addr_o;
                    wcnt  <= lat - 2;
                end
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid0(input string tag, input int budget);
        int k;
        k = 0;
        while (!if0.inst_valid_o && k < budget) begin
            step();
            k++;
        end
        check(tag, {31'b0, if0.inst_valid_o}, 32'd1);
    endtask

    task automatic pop_one();
        if0.inst_ready_i = 1'b1;
        step();
        if0.inst_ready_i = 1'b0;
    endtask

    task automatic reset0();
        rst0 = 1'b0;
        if0.redirect_i    = 1'b0;
        if0.redirect_pc_i = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        step();
        step();
    endtask

    logic [31:0] exp_inst [4];
    logic [31:0] exp_pc   [4];

    initial begin
        lat  = 1;
        rst0 = 1'b0;
        rst1 = 1'b0;
        if0.redirect_i    = 1'b0;
        if0.redirect_pc_i = 32'h0;
        if0.inst_ready_i  = 1'b0;
        if1.redirect_i    = 1'b0;
        if1.redirect_pc_i = 32'h0;
        if1.inst_ready_i  = 1'b0;
        if1.mem_gnt_i     = 1'b0;
        if1.mem_rvalid_i  = 1'b0;
        if1.mem_rdata_i   = 32'h0;

        // Single 32-bit instruction after reset
        reset0();
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0000_0013;
        check("rst_req", {31'b0, if0.mem_req_o}, 32'd0);
        check("rst_valid", {31'b0, if0.inst_valid_o}, 32'd0);
        rst0 = 1'b1;
        #1;
        check("t1_req", {31'b0, if0.mem_req_o}, 32'd1);
        check("t1_addr", if0.mem_addr_o, 32'h0);
        wait_valid0("t1_valid", 10);
        check("t1_inst", if0.inst_o, 32'h0050_0093);
        check("t1_pc", if0.inst_pc_o, 32'h0);
        check("t1_is_c", {31'b0, if0.inst_is_c_o}, 32'd0);
        pop_one();
        wait_valid0("t1_valid2", 10);
        check("t1_inst2", if0.inst_o, 32'h0000_0013);
        check("t1_pc2", if0.inst_pc_o, 32'h4);

        // Two compressed halfwords in one word, ready held high
        reset0();
        mem[0] = 32'h0001_4501;
        if0.inst_ready_i = 1'b1;
        rst0 = 1'b1;
        #1;
        wait_valid0("t2_valid", 10);
        check("t2_inst", if0.inst_o, 32'h0000_4501);
        check("t2_pc", if0.inst_pc_o, 32'h0);
        check("t2_is_c", {31'b0, if0.inst_is_c_o}, 32'd1);
        check("t2_req", {31'b0, if0.mem_req_o}, 32'd1);
        check("t2_addr", if0.mem_addr_o, 32'h4);
        step();
        check("t2_valid2", {31'b0, if0.inst_valid_o}, 32'd1);
        check("t2_inst2", if0.inst_o, 32'h0000_0001);
        check("t2_pc2", if0.inst_pc_o, 32'h2);
        check("t2_is_c2", {31'b0, if0.inst_is_c_o}, 32'd1);
        if0.inst_ready_i = 1'b0;

        // 32-bit instruction straddling a word boundary
        reset0();
        mem[0] = 32'h0093_4501;
        mem[1] = 32'hABCD_0050;
        if0.inst_ready_i = 1'b1;
        rst0 = 1'b1;
        #1;
        wait_valid0("t3_valid", 10);
        check("t3_inst", if0.inst_o, 32'h0000_4501);
        check("t3_pc", if0.inst_pc_o, 32'h0);
        step();
        check("t3_wait_word1", {31'b0, if0.inst_valid_o}, 32'd0);
        step();
        check("t3_valid2", {31'b0, if0.inst_valid_o}, 32'd1);
        check("t3_inst2", if0.inst_o, 32'h0050_0093);
        check("t3_pc2", if0.inst_pc_o, 32'h2);
        check("t3_is_c2", {31'b0, if0.inst_is_c_o}, 32'd0);
        if0.inst_ready_i = 1'b0;

        // Redirect to 0x102 while the fetch of address 8 is outstanding
        reset0();
        lat    = 3;
        mem[0] = 32'h0000_0013;
        mem[1] = 32'h0000_0013;
        mem[2] = 32'h0001_0001;
        mem[64] = 32'h4501_ABCD;
        if0.inst_ready_i = 1'b1;
        rst0 = 1'b1;
        #1;
        for (int k = 0; k < 40; k++) begin
            if (if0.mem_req_o && if0.mem_addr_o == 32'h8) break;
            step();
        end
        check("t4_req8", if0.mem_addr_o, 32'h8);
        step();
        if0.redirect_i    = 1'b1;
        if0.redirect_pc_i = 32'h0000_0102;
        step();
        if0.redirect_i    = 1'b0;
        if0.redirect_pc_i = 32'h0;
        check("t4_valid_after_redir", {31'b0, if0.inst_valid_o}, 32'd0);
        for (int k = 0; k < 20; k++) begin
            if (if0.mem_req_o) break;
            step();
        end
        check("t4_addr", if0.mem_addr_o, 32'h0000_0100);
        wait_valid0("t4_valid", 20);
        check("t4_pc", if0.inst_pc_o, 32'h0000_0102);
        check("t4_inst", if0.inst_o, 32'h0000_4501);
        check("t4_is_c", {31'b0, if0.inst_is_c_o}, 32'd1);
        if0.inst_ready_i = 1'b0;
        lat = 1;

        // Stall for 10 cycles, then drain without losing data
        reset0();
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0001_4501;
        mem[2] = 32'h0000_0013;
        rst0 = 1'b1;
        #1;
        wait_valid0("t5_valid", 10);
        for (int i = 0; i < 10; i++) begin
            step();
            check("t5_hold_inst", if0.inst_o, 32'h0050_0093);
            check("t5_hold_pc", if0.inst_pc_o, 32'h0);
            if (i >= 2) check("t5_no_req", {31'b0, if0.mem_req_o}, 32'd0);
        end
        exp_inst[0] = 32'h0050_0093; exp_pc[0] = 32'h0;
        exp_inst[1] = 32'h0000_4501; exp_pc[1] = 32'h4;
        exp_inst[2] = 32'h0000_0001; exp_pc[2] = 32'h6;
        exp_inst[3] = 32'h0000_0013; exp_pc[3] = 32'h8;
        for (int i = 0; i < 4; i++) begin
            wait_valid0("t5_drain_valid", 10);
            check("t5_drain_inst", if0.inst_o, exp_inst[i]);
            check("t5_drain_pc", if0.inst_pc_o, exp_pc[i]);
            pop_one();
        end

        // RESET_PC = 0x80 instance: asynchronous reset in the middle of WAIT
        check("t6_rst_req", {31'b0, if1.mem_req_o}, 32'd0);
        rst1 = 1'b1;
        #1;
        check("t6_req", {31'b0, if1.mem_req_o}, 32'd1);
        check("t6_addr", if1.mem_addr_o, 32'h80);
        if1.mem_gnt_i = 1'b1;
        step();
        if1.mem_gnt_i    = 1'b0;
        if1.mem_rvalid_i = 1'b1;
        if1.mem_rdata_i  = 32'h0050_0093;
        step();
        if1.mem_rvalid_i = 1'b0;
        check("t6_valid", {31'b0, if1.inst_valid_o}, 32'd1);
        check("t6_pc", if1.inst_pc_o, 32'h80);
        if1.mem_gnt_i = 1'b1;
        step();
        if1.mem_gnt_i = 1'b0;
        rst1 = 1'b0;
        #1;
        check("t6_async_valid", {31'b0, if1.inst_valid_o}, 32'd0);
        check("t6_async_inst", if1.inst_o, 32'h0);
        check("t6_async_is_c", {31'b0, if1.inst_is_c_o}, 32'd0);
        check("t6_async_req", {31'b0, if1.mem_req_o}, 32'd0);
        step();
        step();
        rst1 = 1'b1;
        #1;
        check("t6_req2", {31'b0, if1.mem_req_o}, 32'd1);
        check("t6_addr2", if1.mem_addr_o, 32'h80);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
